// File: rtl/fifo_param_pkg.sv
// Shared defaults and helpers for the parametrised FIFO and the parents that instantiate it.
package fifo_param_pkg;

    localparam int unsigned FIFO_DEFAULT_WIDTH  = 8;
    localparam int unsigned FIFO_DEFAULT_ADDR_W = 4;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Ceiling log2, for parents sizing ADDR_W from a word count.
    function automatic int unsigned fifo_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset.
module fifo_ram
    import fifo_param_pkg::*;
#(
    parameter int unsigned WIDTH  = FIFO_DEFAULT_WIDTH,
    parameter int unsigned ADDR_W = FIFO_DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags,
// sticky error flags and either registered-read or first-word-fall-through output.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int unsigned WIDTH    = FIFO_DEFAULT_WIDTH,
    parameter int unsigned ADDR_W   = FIFO_DEFAULT_ADDR_W,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr,
    input  logic [WIDTH-1:0]  din,
    input  logic              rd,
    output logic [WIDTH-1:0]  dout,
    input  logic              clr_err,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned      DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C     = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C     = (ADDR_W + 1)'(AE_LEVEL);

    if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH || ADDR_W < 1) begin : g_bad_params
        $fatal(1, "fifo_param: illegal parameters (AF_LEVEL > DEPTH, AE_LEVEL >= DEPTH or ADDR_W < 1)");
    end

    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] ram_rdata;
    fifo_flags_t      flags;

    always_comb begin
        flags              = '0;
        flags.full         = (count_q == DEPTH_C);
        flags.empty        = (count_q == '0);
        flags.almost_full  = (count_q >= AF_C);
        flags.almost_empty = (count_q <= AE_C);
    end

    always_comb begin
        rd_acc = rd & ~flags.empty;
        // A write into a full FIFO is fine when a read frees a slot on the same edge.
        wr_acc = wr & (~flags.full | rd_acc);

        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Setting beats a simultaneous clear.
        overflow_d  = (overflow_q  & ~clr_err) | (wr & ~wr_acc);
        underflow_d = (underflow_q & ~clr_err) | (rd & ~rd_acc);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (din),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign dout = flags.empty ? '0 : ram_rdata;
    end else begin : g_reg_read
        logic [WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = rd_acc ? ram_rdata : dout_q;
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign dout = dout_q;
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Randomised and directed bench for fifo_param: a registered-read and an FWFT instance
// share stimulus and are compared every cycle against a queue-based reference.
module tb_fifo_param;

    localparam int unsigned DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] din = '0;

    logic [7:0] dout_r, dout_f;
    logic       full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
    logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [4:0] count_r, count_f;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    logic [7:0] q[$];
    logic [7:0] exp_dout_reg = '0;
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    always #5 clock = ~clock;

    fifo_param #(
        .WIDTH    (8),
        .ADDR_W   (4),
        .FWFT     (0),
        .AF_LEVEL (12),
        .AE_LEVEL (2)
    ) u_dut_reg (
        .clock (clock), .reset (reset), .wr (wr), .din (din), .rd (rd),
        .dout (dout_r), .clr_err (clr_err), .full (full_r), .empty (empty_r),
        .almost_full (af_r), .almost_empty (ae_r), .count (count_r),
        .overflow (ovf_r), .underflow (unf_r)
    );

    fifo_param #(
        .WIDTH    (8),
        .ADDR_W   (4),
        .FWFT     (1),
        .AF_LEVEL (12),
        .AE_LEVEL (2)
    ) u_dut_fwft (
        .clock (clock), .reset (reset), .wr (wr), .din (din), .rd (rd),
        .dout (dout_f), .clr_err (clr_err), .full (full_f), .empty (empty_f),
        .almost_full (af_f), .almost_empty (ae_f), .count (count_f),
        .overflow (ovf_f), .underflow (unf_f)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout_reg = '0;
        exp_ovf      = 1'b0;
        exp_unf      = 1'b0;
    endtask

    // Reference behaviour for one clock edge, from the occupancy rules alone.
    task automatic model_step(input logic w, input logic r, input logic [7:0] d, input logic c);
        bit ra, wa;
        ra = r && (q.size() > 0);
        wa = w && ((q.size() < DEPTH) || ra);
        exp_ovf = (exp_ovf && !c) || (w && !wa);
        exp_unf = (exp_unf && !c) || (r && !ra);
        if (ra) exp_dout_reg = q.pop_front();
        if (wa) q.push_back(d);
    endtask

    task automatic compare_all();
        int unsigned n;
        logic [7:0] head;
        n = q.size();
        head = (n > 0) ? q[0] : 8'h00;
        check_eq("count_reg",  32'(count_r), n);
        check_eq("count_fwft", 32'(count_f), n);
        check_eq("empty_reg",  32'(empty_r), 32'(n == 0));
        check_eq("empty_fwft", 32'(empty_f), 32'(n == 0));
        check_eq("full_reg",   32'(full_r),  32'(n == DEPTH));
        check_eq("full_fwft",  32'(full_f),  32'(n == DEPTH));
        check_eq("afull_reg",  32'(af_r),    32'(n >= 12));
        check_eq("afull_fwft", 32'(af_f),    32'(n >= 12));
        check_eq("aempty_reg", 32'(ae_r),    32'(n <= 2));
        check_eq("aempty_fwft",32'(ae_f),    32'(n <= 2));
        check_eq("ovf_reg",    32'(ovf_r),   32'(exp_ovf));
        check_eq("ovf_fwft",   32'(ovf_f),   32'(exp_ovf));
        check_eq("unf_reg",    32'(unf_r),   32'(exp_unf));
        check_eq("unf_fwft",   32'(unf_f),   32'(exp_unf));
        check_eq("dout_reg",   32'(dout_r),  32'(exp_dout_reg));
        check_eq("dout_fwft",  32'(dout_f),  32'(head));
    endtask

    // Called at posedge+1; applies inputs across one edge and checks just after it.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr = w; rd = r; din = d; clr_err = c;
        @(posedge clock);
        model_step(w, r, d, c);
        #1;
        compare_all();
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        string msg;
        msg = "hola mundo.12345";
        model_reset();

        // Reset held for two edges, then released.
        #2 reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        compare_all();

        // Fill, overflow, drain in order.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, msg[i], 1'b0);
        cycle(1'b1, 1'b0, "6", 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous read/write at full, then at empty.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, msg[i], 1'b0);
        cycle(1'b1, 1'b1, "a", 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, "b", 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Wrap-around: pointers pass twice the depth.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
            for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Randomised traffic with shifting write bias to reach both ends.
        for (int p = 0; p < 4; p++) begin
            int unsigned wbias;
            wbias = (p % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 100; i++) begin
                cycle(1'($urandom_range(0, 99) < wbias),
                      1'($urandom_range(0, 99) < 50),
                      8'($urandom),
                      1'($urandom_range(0, 19) == 0));
            end
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-burst at count 7.
        while (q.size() < 7) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
        while (q.size() > 7) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_eq("async_count_reg",  32'(count_r), 0);
        check_eq("async_count_fwft", 32'(count_f), 0);
        check_eq("async_empty_reg",  32'(empty_r), 1);
        check_eq("async_empty_fwft", 32'(empty_f), 1);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        compare_all();
        cycle(1'b1, 1'b0, 8'h5a, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
